// File: rtl/dma_pkg.sv
// Shared types and widths for the DMA bus arbiter and its burst counter.
package dma_pkg;

    localparam int unsigned BURST_W = 9;
    localparam int unsigned GAP_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_REQ,
        ST_SETTLE,
        ST_GRANT,
        ST_RELEASE
    } dma_state_e;

    // A requested length of 0 stands for the maximum burst of 256 cycles.
    function automatic logic [BURST_W-1:0] burst_len(input logic [7:0] len);
        return (len == 8'd0) ? {1'b1, 8'h00} : {1'b0, len};
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_burst_counter.sv
// Burst length down-counter: loads the accepted length, counts grant cycles,
// flags the final one.
module burst_counter
    import dma_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] len,
    output logic       is_last
);

    logic [BURST_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= burst_len(len);
        end else if (dec && (count != '0)) begin
            count <= count - BURST_W'(1);
        end
    end

    assign is_last = (count == BURST_W'(1));

endmodule

// File: rtl/dma_bus_arbiter.sv
// Halts the CPU on a read cycle, hands the bus to a DMA requester for a fixed
// burst, then returns it and enforces a minimum CPU-owned gap between bursts.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned MIN_GAP = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       dma_req,
    input  logic [7:0] dma_len,
    input  logic       cpu_rw_n,
    output logic       READY,
    output logic       cpu_bus_en,
    output logic       dma_grant,
    output logic       dma_done,
    output logic       dma_busy
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

    dma_state_e       state, next;
    logic [GAP_W-1:0] gap;
    logic             burst_load;
    logic             burst_dec;
    logic             burst_last;
    logic             done_nxt;

    burst_counter u_burst (
        .clk     (clk_2),
        .reset   (reset),
        .load    (burst_load),
        .dec     (burst_dec),
        .len     (dma_len),
        .is_last (burst_last)
    );

    always_comb begin
        next       = state;
        burst_load = 1'b0;
        burst_dec  = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            // Accept on the IDLE cycle that runs the gap out, so the CPU gets
            // exactly MIN_GAP IDLE cycles; a zero gap skips IDLE entirely.
            ST_IDLE: begin
                if (dma_req && (gap <= GAP_W'(1))) begin
                    next       = ST_HALT_REQ;
                    burst_load = 1'b1;
                end
            end
            ST_HALT_REQ: begin
                if (!dma_req) begin
                    next = ST_IDLE;
                end else if (cpu_rw_n) begin
                    next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                next = dma_req ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                burst_dec = 1'b1;
                if (!dma_req) begin
                    next = ST_RELEASE;
                end else if (burst_last) begin
                    next     = ST_RELEASE;
                    done_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if ((MIN_GAP == 0) && dma_req) begin
                    next       = ST_HALT_REQ;
                    burst_load = 1'b1;
                end else begin
                    next = ST_IDLE;
                end
            end
            default: next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they stay Moore.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            READY      <= 1'b1;
            cpu_bus_en <= 1'b1;
            dma_grant  <= 1'b0;
            dma_done   <= 1'b0;
            dma_busy   <= 1'b0;
        end else begin
            state      <= next;
            READY      <= (next == ST_IDLE) || (next == ST_RELEASE);
            cpu_bus_en <= (next == ST_IDLE) || (next == ST_HALT_REQ) || (next == ST_SETTLE);
            dma_grant  <= (next == ST_GRANT);
            dma_done   <= done_nxt;
            dma_busy   <= (next != ST_IDLE);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else if (state == ST_RELEASE) begin
            gap <= GAP_LOAD;
        end else if ((state == ST_IDLE) && (gap != '0)) begin
            gap <= gap - GAP_W'(1);
        end
    end

endmodule
